// File: rtl/reg_word_serializer.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word on a valid/ready handshake, emits it one bit per beat.
// Latency: a word accepted at edge N presents its first bit during cycle N+1; words stream back to back.
// Backpressure: O_READY low freezes O/O_LAST/counter/shift register; I_READY only rises in IDLE or on an accepted last beat.
module reg_word_serializer #(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic             O,
  output logic             O_VALID,
  output logic             O_LAST,
  input  logic             O_READY
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;

  logic in_shift;
  logic at_last;
  logic out_bit;

  assign in_shift = (state_q == SHIFT);
  assign at_last  = (cnt_q == LAST_CNT);
  assign out_bit  = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];

  // Outputs come straight from state; only I_READY looks at O_READY so the next word can follow the last bit.
  always_comb begin
    O_VALID = in_shift;
    O       = in_shift & out_bit;
    O_LAST  = in_shift & at_last;
    I_READY = ~in_shift | (at_last & O_READY);
  end

  // Next-state: load on accept, shift on each consumed beat, fall back to IDLE when no word follows the last bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      IDLE: begin
        if (I_VALID) begin
          sreg_d  = I;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (O_READY) begin
          if (!at_last) begin
            if (MSB_FIRST != 0) begin
              sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            end else begin
              sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
          end else if (I_VALID) begin
            sreg_d = I;
            cnt_d  = '0;
          end else begin
            sreg_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops any word in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

endmodule

// File: doc/reg_word_serializer.md
Name: reg_word_serializer

Overview:
Parallel-in/serial-out transmitter for 16-bit register words. It is the sending end of the word-register datapath: it accepts a word from a register stage such as my_register through a valid/ready handshake. It then shifts the word out one bit per accepted beat, with a valid/ready handshake and an end-of-word strobe, to a serial link or deserializer.

Parameters:
WIDTH, 16, word width in bits; legal range is WIDTH >= 2.
MSB_FIRST, 1, 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset.
I  input  WIDTH  parallel word in.
I_VALID  input  1  I holds a word to send.
I_READY  output  1  block accepts I on this edge.
O  output  1  current serial bit.
O_VALID  output  1  O is a valid bit.
O_LAST  output  1  O is the final bit of the word.
O_READY  input  1  downstream consumes O on this edge.

Behaviour:
- Clocking and reset: one clock, CLK. RESET is synchronous and active-high.
  - RESET sampled high at an edge forces state IDLE, bit counter 0, shift register 0.
  - After that edge: O=0, O_VALID=0, O_LAST=0, I_READY=1.
  - RESET has priority over all handshakes. I_VALID is ignored during RESET.
- States: IDLE and SHIFT. The counter is clog2(WIDTH) bits wide and counts beats sent within the word.
- IDLE behaviour:
  - Outputs: O_VALID=0, O=0, O_LAST=0, I_READY=1.
  - On an edge with I_VALID&I_READY: load the shift register with I, set counter to 0, go to SHIFT.
- SHIFT behaviour:
  - O_VALID=1.
  - O is the shift register's MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0). O comes only from registers, with no combinational path from I.
  - O_LAST=1 exactly when counter==WIDTH-1.
- Beat acceptance in SHIFT, on an edge with O_READY=1:
  - If counter<WIDTH-1: shift one position toward the output end and increment the counter.
  - If counter==WIDTH-1 (last beat) and I_VALID=1: load I, set counter to 0, stay in SHIFT. There is no bubble between words.
  - If counter==WIDTH-1 (last beat) and I_VALID=0: go to IDLE.
- Backpressure: while O_VALID=1 and O_READY=0, O, O_LAST, the counter and the shift register hold stable.
- I_READY = (state==IDLE) | (state==SHIFT & counter==WIDTH-1 & O_READY).
  - This is the only combinational input-to-output path (O_READY to I_READY).
  - I is never accepted mid-word.
- Latency: a word accepted at edge N shows its first bit during cycle N+1.
- Throughput: with O_READY held high, one word per WIDTH cycles.
- Reset mid-word: the remaining bits are dropped and O_LAST is never emitted for the aborted word. The next word starts at its first bit.
- O_VALID never drops mid-word unless RESET is asserted.

Test Plan:
1. RESET high for 2 cycles with I_VALID=1, I=16'hFFFF -> afterwards O_VALID=0, O=0, O_LAST=0, I_READY=1, and no word is loaded.
2. MSB_FIRST=1, I=16'hA5C3 accepted, O_READY=1 -> O over 16 cycles = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; O_LAST only on the 16th; O_VALID=0 in cycle 17.
3. Back-to-back: 16'hFFFF then 16'h0001, I_VALID held, O_READY=1 -> I_READY=1 only in IDLE and on the last-bit cycle; 32 contiguous valid bits (16 ones, 15 zeros, 1 one); O_LAST on bits 16 and 32.
4. Backpressure: O_READY=0 for 3 cycles while bit index 5 is presented -> O and O_LAST stable, I_READY=0; sending resumes at bit index 5 with no bit lost or duplicated.
5. RESET asserted for one cycle after 7 bits of 16'hA5C3 -> O_VALID=0 the next cycle. A new word 16'h8000 then sends 1 followed by 15 zeros.
6. MSB_FIRST=0, I=16'h8001 -> first bit 1, then 14 zeros, then the last bit 1 with O_LAST=1.
